// File: rtl/tetris_pkg.sv
// Shared Tetris types: user commands, piece identities and the move-scheduler
// op/state encodings plus the command payload offered to the executioner.
package tetris_pkg;

  localparam int unsigned CMD_W   = 2;
  localparam int unsigned PIECE_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_LEFT   = 2'd0,
    CMD_RIGHT  = 2'd1,
    CMD_ROTATE = 2'd2,
    CMD_DROP   = 2'd3
  } command_t;

  typedef enum logic [PIECE_W-1:0] {
    HERO           = 3'd0,
    TEEWEE         = 3'd1,
    SMASHBOY       = 3'd2,
    ORANGE_RICKY   = 3'd3,
    BLUE_RICKY     = 3'd4,
    CLEVELAND_Z    = 3'd5,
    RHODE_ISLAND_Z = 3'd6
  } active_piece_t;

  typedef enum logic [1:0] {
    OP_USER    = 2'd0,
    OP_GRAVITY = 2'd1,
    OP_SPAWN   = 2'd2
  } sched_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    ACTIVE    = 3'd2,
    WAIT      = 3'd3,
    GAME_OVER = 3'd4
  } sched_state_t;

  typedef struct packed {
    sched_op_t     op;
    command_t      move;
    active_piece_t piece;
  } sched_cmd_t;

endpackage

// File: rtl/move_fifo.sv
// Power-of-two circular queue of user moves with push, pop and flush.
// Head/full/empty are combinational views of the registered storage.
module move_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             game_clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_c_o,
  output logic             full_c_o,
  output logic             empty_c_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_c_o  = (count_q == CW'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign head_c_o  = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves the same cycle.
  always_comb begin
    pop_ok   = pop_i && !empty_c_o;
    push_ok  = push_i && (!full_c_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge game_clk) begin
    if (reset_n && push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates user moves, gravity drops and piece spawns towards the
// executioner with a valid/ready offer and a done/blocked completion.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned GRAVITY_PERIOD = 32
) (
  input  logic          game_clk,
  input  logic          reset_n,
  input  logic          move_in_valid,
  input  command_t      move_in,
  input  active_piece_t piece_in,
  output logic          exec_valid,
  input  logic          exec_ready,
  output sched_op_t     exec_op,
  output command_t      exec_move,
  output active_piece_t exec_piece,
  input  logic          exec_done,
  input  logic          exec_blocked,
  output logic          game_over,
  output logic [7:0]    dropped_moves
);

  localparam int unsigned GW = (GRAVITY_PERIOD > 2) ? $clog2(GRAVITY_PERIOD) : 1;

  sched_state_t     state_q, state_d;
  sched_cmd_t       cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic [GW-1:0]    grav_cnt_q, grav_cnt_d;
  logic             grav_due_q, grav_due_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             game_over_q, game_over_d;

  logic             accept, push_window, spawn_entry;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .game_clk  (game_clk),
    .reset_n   (reset_n),
    .push_i    (fifo_push),
    .data_i    (move_in),
    .pop_i     (fifo_pop),
    .flush_i   (fifo_flush),
    .head_c_o  (fifo_head),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  assign accept      = valid_q && exec_ready;
  assign push_window = (state_q == SPAWN) || (state_q == ACTIVE) || (state_q == WAIT);

  // Next-state, offer register and queue control.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    valid_d    = valid_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      IDLE: state_d = SPAWN;
      SPAWN: begin
        if (accept) begin
          state_d = WAIT;
          valid_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (valid_q) begin
          if (accept) begin
            state_d  = WAIT;
            valid_d  = 1'b0;
            fifo_pop = (cmd_q.op == OP_USER);
          end
        end else if (grav_due_q) begin
          valid_d = 1'b1;
          cmd_d   = '{op: OP_GRAVITY, move: CMD_LEFT, piece: cmd_q.piece};
        end else if (!fifo_empty) begin
          valid_d = 1'b1;
          cmd_d   = '{op: OP_USER, move: command_t'(fifo_head), piece: cmd_q.piece};
        end else if (move_in_valid) begin
          // Empty queue: offer the arriving move directly; it is pushed now and popped on accept.
          valid_d = 1'b1;
          cmd_d   = '{op: OP_USER, move: move_in, piece: cmd_q.piece};
        end
      end
      WAIT: begin
        if (exec_done) begin
          if (exec_blocked && (cmd_q.op == OP_GRAVITY)) begin
            fifo_flush = 1'b1;
            state_d    = SPAWN;
          end else if (exec_blocked && (cmd_q.op == OP_SPAWN)) begin
            state_d = GAME_OVER;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase

    spawn_entry = (state_d == SPAWN) && (state_q != SPAWN);
    if (spawn_entry) begin
      valid_d = 1'b1;
      cmd_d   = '{op: OP_SPAWN, move: CMD_LEFT, piece: piece_in};
    end
    game_over_d = (state_d == GAME_OVER);
  end

  // Queue admission and saturating drop counter; flush cycles swallow pushes.
  always_comb begin
    fifo_push = 1'b0;
    dropped_d = dropped_q;
    if (move_in_valid && push_window && !fifo_flush) begin
      if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
      end else if (dropped_q != 8'hFF) begin
        dropped_d = dropped_q + 8'd1;
      end
    end
  end

  // Gravity timer: runs while a piece is in play, sticky due flag until served.
  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_due_d = grav_due_q;
    if (accept && (state_q == ACTIVE) && (cmd_q.op == OP_GRAVITY)) grav_due_d = 1'b0;
    if ((state_q == ACTIVE) || (state_q == WAIT)) begin
      if (grav_cnt_q == GW'(GRAVITY_PERIOD - 1)) begin
        grav_cnt_d = '0;
        grav_due_d = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GW'(1);
      end
    end
    if (spawn_entry) begin
      grav_cnt_d = '0;
      grav_due_d = 1'b0;
    end
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= '{op: OP_USER, move: CMD_LEFT, piece: HERO};
      valid_q     <= 1'b0;
      grav_cnt_q  <= '0;
      grav_due_q  <= 1'b0;
      dropped_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_due_q  <= grav_due_d;
      dropped_q   <= dropped_d;
      game_over_q <= game_over_d;
    end
  end

  assign exec_valid    = valid_q;
  assign exec_op       = cmd_q.op;
  assign exec_move     = cmd_q.move;
  assign exec_piece    = cmd_q.piece;
  assign game_over     = game_over_q;
  assign dropped_moves = dropped_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with GRAVITY_PERIOD=8, FIFO_DEPTH=4 and an
// executioner model that pulses done two cycles after each acceptance.
module tb_move_scheduler;
  import tetris_pkg::*;

  logic          game_clk = 1'b0;
  logic          reset_n;
  logic          move_in_valid;
  command_t      move_in;
  active_piece_t piece_in;
  logic          exec_valid;
  logic          exec_ready;
  sched_op_t     exec_op;
  command_t      exec_move;
  active_piece_t exec_piece;
  logic          exec_done;
  logic          exec_blocked;
  logic          game_over;
  logic [7:0]    dropped_moves;

  int n_checks = 0;
  int n_errors = 0;

  always #5 game_clk = ~game_clk;

  move_scheduler #(
    .FIFO_DEPTH     (4),
    .GRAVITY_PERIOD (8)
  ) dut (
    .game_clk      (game_clk),
    .reset_n       (reset_n),
    .move_in_valid (move_in_valid),
    .move_in       (move_in),
    .piece_in      (piece_in),
    .exec_valid    (exec_valid),
    .exec_ready    (exec_ready),
    .exec_op       (exec_op),
    .exec_move     (exec_move),
    .exec_piece    (exec_piece),
    .exec_done     (exec_done),
    .exec_blocked  (exec_blocked),
    .game_over     (game_over),
    .dropped_moves (dropped_moves)
  );

  task automatic step();
    @(posedge game_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && exec_valid !== 1'b1; i++) step();
    chk({tag, "_valid"}, 32'(exec_valid), 32'd1);
  endtask

  // Accept on the next edge, then return done/blocked two cycles later.
  task automatic complete(input string tag, input logic blk);
    step();
    chk({tag, "_drop_valid"}, 32'(exec_valid), 32'd0);
    step();
    exec_done    = 1'b1;
    exec_blocked = blk;
    step();
    exec_done    = 1'b0;
    exec_blocked = 1'b0;
  endtask

  task automatic serve(input string tag, input sched_op_t op, input command_t mv,
                       input active_piece_t pc, input logic blk);
    exec_ready = 1'b1;
    wait_valid(tag);
    chk({tag, "_op"}, 32'(exec_op), 32'(op));
    if (op == OP_SPAWN) chk({tag, "_piece"}, 32'(exec_piece), 32'(pc));
    else                chk({tag, "_move"}, 32'(exec_move), 32'(mv));
    complete(tag, blk);
  endtask

  // Gravity drops may legitimately interleave; the user moves must keep order.
  task automatic serve_user(input string tag, input command_t mv);
    exec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(tag);
      if (exec_op == OP_GRAVITY) complete({tag, "_grav"}, 1'b0);
      else break;
    end
    chk({tag, "_op"}, 32'(exec_op), 32'(OP_USER));
    chk({tag, "_move"}, 32'(exec_move), 32'(mv));
    complete(tag, 1'b0);
  endtask

  initial begin
    reset_n       = 1'b0;
    move_in_valid = 1'b0;
    move_in       = CMD_LEFT;
    piece_in      = TEEWEE;
    exec_ready    = 1'b1;
    exec_done     = 1'b0;
    exec_blocked  = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(exec_valid), 32'd0);
    chk("rst_op", 32'(exec_op), 32'(OP_USER));
    chk("rst_move", 32'(exec_move), 32'd0);
    chk("rst_piece", 32'(exec_piece), 32'(HERO));
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_dropped", 32'(dropped_moves), 32'd0);

    // First spawn one cycle after reset release.
    reset_n = 1'b1;
    step();
    chk("spawn1_valid", 32'(exec_valid), 32'd1);
    chk("spawn1_op", 32'(exec_op), 32'(OP_SPAWN));
    chk("spawn1_piece", 32'(exec_piece), 32'(TEEWEE));
    serve("spawn1", OP_SPAWN, CMD_LEFT, TEEWEE, 1'b0);

    // Single move while idle in ACTIVE: offered the very next cycle.
    move_in_valid = 1'b1;
    move_in       = CMD_ROTATE;
    step();
    move_in_valid = 1'b0;
    chk("lat_valid", 32'(exec_valid), 32'd1);
    chk("lat_op", 32'(exec_op), 32'(OP_USER));
    chk("lat_move", 32'(exec_move), 32'(CMD_ROTATE));
    serve("lat", OP_USER, CMD_ROTATE, HERO, 1'b0);

    // Six pushes against a stalled executioner: four kept, two dropped.
    exec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      move_in_valid = 1'b1;
      move_in       = command_t'(2'(i));
      step();
    end
    move_in_valid = 1'b0;
    chk("burst_dropped", 32'(dropped_moves), 32'd2);
    chk("burst_hold_valid", 32'(exec_valid), 32'd1);
    chk("burst_hold_op", 32'(exec_op), 32'(OP_USER));
    chk("burst_hold_move", 32'(exec_move), 32'(CMD_LEFT));
    serve("burst0", OP_USER, CMD_LEFT, HERO, 1'b0);
    // Gravity became due while moves were still queued: it goes first.
    serve("grav_prio", OP_GRAVITY, CMD_LEFT, HERO, 1'b0);
    serve_user("burst1", CMD_RIGHT);
    serve_user("burst2", CMD_ROTATE);
    serve_user("burst3", CMD_DROP);

    // Blocked gravity with three queued moves: flush and respawn.
    exec_ready = 1'b0;
    wait_valid("lock_wait");
    chk("lock_wait_op", 32'(exec_op), 32'(OP_GRAVITY));
    for (int i = 0; i < 3; i++) begin
      move_in_valid = 1'b1;
      move_in       = command_t'(2'(i + 1));
      step();
    end
    move_in_valid = 1'b0;
    chk("lock_dropped", 32'(dropped_moves), 32'd2);
    piece_in = SMASHBOY;
    serve("lock", OP_GRAVITY, CMD_LEFT, HERO, 1'b1);
    chk("respawn_valid", 32'(exec_valid), 32'd1);
    chk("respawn_op", 32'(exec_op), 32'(OP_SPAWN));
    chk("respawn_piece", 32'(exec_piece), 32'(SMASHBOY));
    chk("respawn_grav_cnt", 32'(dut.grav_cnt_q), 32'd0);
    serve("respawn", OP_SPAWN, CMD_LEFT, SMASHBOY, 1'b0);
    // Flushed queue: the next command can only be gravity.
    serve("post_flush", OP_GRAVITY, CMD_LEFT, HERO, 1'b1);

    // Blocked spawn ends the game.
    serve("dead_spawn", OP_SPAWN, CMD_LEFT, SMASHBOY, 1'b1);
    chk("go_flag", 32'(game_over), 32'd1);
    chk("go_valid", 32'(exec_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      move_in_valid = 1'b1;
      move_in       = CMD_DROP;
      step();
    end
    move_in_valid = 1'b0;
    step();
    chk("go_push_valid", 32'(exec_valid), 32'd0);
    chk("go_push_flag", 32'(game_over), 32'd1);
    chk("go_push_dropped", 32'(dropped_moves), 32'd2);

    reset_n = 1'b0;
    step();
    chk("rst2_valid", 32'(exec_valid), 32'd0);
    chk("rst2_op", 32'(exec_op), 32'(OP_USER));
    chk("rst2_move", 32'(exec_move), 32'd0);
    chk("rst2_piece", 32'(exec_piece), 32'(HERO));
    chk("rst2_game_over", 32'(game_over), 32'd0);
    chk("rst2_dropped", 32'(dropped_moves), 32'd0);

    // Stalled spawn with a continuous push stream: drop counter saturates.
    piece_in   = ORANGE_RICKY;
    exec_ready = 1'b0;
    reset_n    = 1'b1;
    step();
    chk("sat_spawn_op", 32'(exec_op), 32'(OP_SPAWN));
    chk("sat_spawn_piece", 32'(exec_piece), 32'(ORANGE_RICKY));
    move_in_valid = 1'b1;
    move_in       = CMD_RIGHT;
    repeat (300) step();
    move_in_valid = 1'b0;
    chk("sat_dropped", 32'(dropped_moves), 32'd255);
    chk("sat_hold_valid", 32'(exec_valid), 32'd1);
    chk("sat_hold_op", 32'(exec_op), 32'(OP_SPAWN));

    // Reset while an offer is outstanding abandons it.
    reset_n = 1'b0;
    step();
    chk("abandon_valid", 32'(exec_valid), 32'd0);
    chk("abandon_dropped", 32'(dropped_moves), 32'd0);
    chk("abandon_piece", 32'(exec_piece), 32'(HERO));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
